regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Writeback arbiter and pending-write scoreboard for the 32 x 32-bit register file. It shares the register file's single synchronous write port among several writeback sources (ALU, load/store unit, multiply/divide) using round-robin with a valid/ready handshake, then drives the port from registered outputs. It also keeps a busy bitmap of registers that have an outstanding producer, which issue logic uses for hazard stalls.

## Interface
- NUM_SRC, default 3: number of writeback sources; legal range 2..8.
- clk_i  in  1: clock; every register updates on its rising edge.
- rst_ni  in  1: reset, synchronous and active-low.
- src_valid_i  in  NUM_SRC: source n is offering a writeback.
- src_addr_i  in  NUM_SRC x regaddr_t: destination register for each source.
- src_data_i  in  NUM_SRC x word_t: writeback data for each source.
- src_ready_o  out  NUM_SRC: one-hot or zero; a writeback transfers when valid and ready are both high.
- write_enable_o  out  1: drives the register file write enable.
- write_addr_o  out  regaddr_t: drives the register file write address.
- write_data_o  out  word_t: drives the register file write data.
- claim_valid_i  in  1: issue logic is reserving a destination register.
- claim_addr_i  in  regaddr_t: the register being reserved.
- busy_o  out  32: bit r is high while register r has an outstanding producer.

## Operation
- **Grant**
  - src_ready_o is combinational from src_valid_i and the priority pointer.
  - Exactly one valid source is granted per cycle; none are granted if none are valid.
  - The output stage drains every cycle, so there is no back-pressure from the register file.
- **Round-robin**
  - ptr holds the index of the last granted source.
  - Search order is ptr+1, ptr+2, … modulo NUM_SRC.
  - ptr updates to the granted index only on a transfer; it holds when idle.
- **Source rules**
  - Sources hold valid, addr and data stable until the transfer.
  - Sources do not retract valid before the transfer.
- **Output stage**
  - On a transfer, register write_addr_o and write_data_o from the granted source.
  - Register write_enable_o as 1, except that write_enable_o stays 0 when the address is x0.
  - Otherwise write_enable_o returns to 0 and address/data hold their last values.
- **Scoreboard**
  - A claim with claim_valid_i high sets busy[claim_addr_i].
  - A cycle with write_enable_o high clears busy[write_addr_o].
  - Claim and clear of the same register in the same cycle: the claim wins and the bit stays 1 (new producer).
  - A claim of x0 is ignored; busy[0] is constant 0.
  - A second claim of an already-busy register leaves it set.
- **Reset**
  - ptr resets to NUM_SRC-1, so source 0 has first priority.
  - write_enable_o, write_addr_o, write_data_o and busy_o reset to 0.
  - src_ready_o is forced to 0 while rst_ni is low.
  - An accepted writeback that is registered but not yet committed is discarded by reset.

## Timing
- **Cycle T:** valid and ready are both high; the source's data is captured at the end of T.
- **Cycle T+1:** write_* are presented to the register file, which commits at the end of T+1.
- **Busy clear:** the busy bit falls at the same edge as the commit, so a read after busy falls returns the new value.
- **Throughput:** one writeback per cycle in aggregate.
- **Fairness:** with all sources continuously valid, each source is granted once every NUM_SRC cycles.
- **Worst-case wait:** NUM_SRC-1 cycles from valid to ready.
- **Critical path:** valid → ready is combinational; sources must not derive valid from ready.

## Structure
- **Shared package (common):**
  - `regaddr_t` and `word_t`, which already exist.
  - New constant `NUM_WB_SRC = 3`.
  - New enum `wb_src_t` with values ALU=0, LSU=1, MDU=2, so source indices are named everywhere.
- **Sub-module:** `rr_arbiter`, a parameterised round-robin arbiter.
  - Inputs: request vector and transfer indication.
  - Outputs: one-hot grant and encoded index.
  - Owns ptr.
- **Top level:** the output register and the busy bitmap live in `regfile_wb_arbiter` itself.

## Test plan
- **Single source:** after reset, src1 valid with addr=5, data=0xDEADBEEF for one cycle.
  - Required: ready1 high in that cycle.
  - Required: next cycle write_enable_o=1, addr 5, data 0xDEADBEEF.
  - Required: a register-file read of 5 returns 0xDEADBEEF afterwards.
- **All sources valid:** all three sources valid continuously for 6 cycles, with distinct addresses.
  - Required: grant order 0,1,2,0,1,2.
  - Required: six consecutive write_enable_o pulses carrying matching addr/data.
- **Write to x0:** src0 valid with addr=0, data=0x1234.
  - Required: the transfer completes (ready0 high).
  - Required: write_enable_o stays 0.
  - Required: register 0 still reads 0.
- **Scoreboard set and clear:** claim addr=7, then src2 writes addr 7.
  - Required: busy_o[7] is high from the cycle after the claim.
  - Required: busy_o[7] falls at the commit edge.
  - Claim 0 → busy_o stays 0.
- **Claim/clear collision:** claim addr=9 in the same cycle that write_enable_o commits addr 9.
  - Required: busy_o[9] remains 1.
- **Reset mid-operation:** accept a writeback to addr 3, then drive rst_ni low at the next edge.
  - Required: write_enable_o=0 and busy_o=0.
  - Required: register 3 is unchanged.
  - Required: after rst_ni rises, with all sources valid, source 0 is granted first.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
// Shared types and constants for the register-file writeback path.
//   regaddr_t  : 5-bit register index (x0..x31)
//   word_t     : 32-bit register data
//   NUM_WB_SRC : number of writeback sources in the default core configuration
//   wb_src_t   : named writeback source indices
// -----------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

   typedef logic [4:0]  regaddr_t;
   typedef logic [31:0] word_t;

   localparam int NUM_REGS   = 32;
   localparam int NUM_WB_SRC = 3;

   typedef enum logic [1:0] {
      ALU = 2'd0,
      LSU = 2'd1,
      MDU = 2'd2
   } wb_src_t;

   // x0 is hardwired to zero, so it is never written and never tracked.
   function automatic logic is_x0(input regaddr_t a);
      return (a == '0);
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Parameterised round-robin arbiter. The pointer holds the index of the last
// granted requester; the search starts at ptr+1 and wraps modulo N.
// Ports:
//   i_clk    : clock
//   i_rst_n  : synchronous active-low reset; pointer goes to N-1 so that
//              requester 0 has first priority, and grants are forced low
//   i_req    : request vector
//   i_xfer   : a grant was consumed this cycle; pointer advances only then
//   o_gnt    : one-hot grant, or zero when nothing requests
//   o_idx    : encoded index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N = 3,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [N-1:0]  i_req,
   input  logic          i_xfer,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx
);

   // One extra bit so ptr + offset (at most 2N-1) cannot overflow before wrap.
   localparam int CW = IW + 1;

   logic [IW-1:0] r_ptr;
   logic [N-1:0]  w_gnt;
   logic [IW-1:0] w_idx;
   logic [CW-1:0] w_cand;
   logic          w_found;

   always_comb begin
      w_gnt   = '0;
      w_idx   = r_ptr;
      w_cand  = '0;
      w_found = 1'b0;
      for (int i = 1; i <= N; i++) begin
         w_cand = {1'b0, r_ptr} + CW'(i);
         if (w_cand >= CW'(N)) begin
            w_cand = w_cand - CW'(N);
         end
         if (!w_found && i_req[w_cand[IW-1:0]]) begin
            w_found                 = 1'b1;
            w_gnt[w_cand[IW-1:0]]   = 1'b1;
            w_idx                   = w_cand[IW-1:0];
         end
      end
      if (!i_rst_n) begin
         w_gnt = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_ptr <= IW'(N - 1);
      end else if (i_xfer) begin
         r_ptr <= w_idx;
      end
   end

   assign o_gnt = w_gnt;
   assign o_idx = w_idx;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the register file's single write port among NUM_SRC writeback
// sources (round-robin, valid/ready) and drives the port from registers.
// Also keeps a busy bitmap of registers with an outstanding producer.
// Ports:
//   clk_i, rst_ni                 : clock, synchronous active-low reset
//   src_valid_i/addr_i/data_i     : writeback offers from each source
//   src_ready_o                   : one-hot grant (combinational from valid)
//   write_enable_o/addr_o/data_o  : register file write port
//   claim_valid_i/claim_addr_i    : issue logic reserving a destination
//   busy_o                        : per-register outstanding-producer flag
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NUM_SRC = NUM_WB_SRC
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NUM_SRC-1:0]      src_valid_i,
   input  regaddr_t [NUM_SRC-1:0]  src_addr_i,
   input  word_t    [NUM_SRC-1:0]  src_data_i,
   output logic [NUM_SRC-1:0]      src_ready_o,
   output logic                    write_enable_o,
   output regaddr_t                write_addr_o,
   output word_t                   write_data_o,
   input  logic                    claim_valid_i,
   input  regaddr_t                claim_addr_i,
   output logic [NUM_REGS-1:0]     busy_o
);

   localparam int IW = $clog2(NUM_SRC);

   logic [NUM_SRC-1:0]  w_gnt;
   logic [IW-1:0]       w_idx;
   logic                w_xfer;
   logic                r_we;
   regaddr_t            r_waddr;
   word_t               r_wdata;
   logic [NUM_REGS-1:0] r_busy;
   logic [NUM_REGS-1:0] w_busy_nxt;

   rr_arbiter #(
      .N (NUM_SRC)
   ) u_rr_arbiter (
      .i_clk   (clk_i),
      .i_rst_n (rst_ni),
      .i_req   (src_valid_i),
      .i_xfer  (w_xfer),
      .o_gnt   (w_gnt),
      .o_idx   (w_idx)
   );

   assign src_ready_o = w_gnt;
   assign w_xfer      = |(src_valid_i & w_gnt);

   // A transfer to x0 still completes the handshake but never reaches the port.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else if (w_xfer) begin
         r_we    <= !is_x0(src_addr_i[w_idx]);
         r_waddr <= src_addr_i[w_idx];
         r_wdata <= src_data_i[w_idx];
      end else begin
         r_we    <= 1'b0;
      end
   end

   // Gate with reset so a registered-but-uncommitted write is dropped the
   // moment reset asserts, not one edge later.
   assign write_enable_o = r_we & rst_ni;
   assign write_addr_o   = r_waddr;
   assign write_data_o   = r_wdata;

   // Clear first, then set: a claim in the commit cycle marks a new producer.
   always_comb begin
      w_busy_nxt = r_busy;
      if (r_we) begin
         w_busy_nxt[r_waddr] = 1'b0;
      end
      if (claim_valid_i && !is_x0(claim_addr_i)) begin
         w_busy_nxt[claim_addr_i] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   assign busy_o = r_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
   import regfile_wb_arbiter_pkg::*;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic [2:0]      src_valid_i;
   regaddr_t [2:0]  src_addr_i;
   word_t    [2:0]  src_data_i;
   logic [2:0]      src_ready_o;
   logic            write_enable_o;
   regaddr_t        write_addr_o;
   word_t           write_data_o;
   logic            claim_valid_i;
   regaddr_t        claim_addr_i;
   logic [31:0]     busy_o;

   int n_checks = 0;
   int n_errors = 0;

   word_t rf [32] = '{default: '0};

   regfile_wb_arbiter #(.NUM_SRC(3)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .src_valid_i    (src_valid_i),
      .src_addr_i     (src_addr_i),
      .src_data_i     (src_data_i),
      .src_ready_o    (src_ready_o),
      .write_enable_o (write_enable_o),
      .write_addr_o   (write_addr_o),
      .write_data_o   (write_data_o),
      .claim_valid_i  (claim_valid_i),
      .claim_addr_i   (claim_addr_i),
      .busy_o         (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // register file model: commits on the rising edge when enabled
   always @(posedge clk_i) begin
      if (write_enable_o) rf[write_addr_o] <= write_data_o;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_ni        = 1'b0;
      src_valid_i   = 3'b111;
      src_addr_i    = '0;
      src_data_i    = '0;
      claim_valid_i = 1'b1;
      claim_addr_i  = 5'd4;

      // reset state
      tick();
      tick();
      chk("rst_ready", 32'(src_ready_o), 32'h0);
      chk("rst_we",    32'(write_enable_o), 32'h0);
      chk("rst_waddr", 32'(write_addr_o), 32'h0);
      chk("rst_wdata", write_data_o, 32'h0);
      chk("rst_busy",  busy_o, 32'h0);
      @(negedge clk_i);
      rst_ni        = 1'b1;
      src_valid_i   = 3'b000;
      claim_valid_i = 1'b0;

      // single source
      @(negedge clk_i);
      src_valid_i[LSU] = 1'b1;
      src_addr_i[LSU]  = 5'd5;
      src_data_i[LSU]  = 32'hDEADBEEF;
      #1 chk("single_ready", 32'(src_ready_o), 32'h2);
      tick();
      chk("single_we",    32'(write_enable_o), 32'h1);
      chk("single_waddr", 32'(write_addr_o), 32'd5);
      chk("single_wdata", write_data_o, 32'hDEADBEEF);
      @(negedge clk_i);
      src_valid_i = 3'b000;
      tick();
      chk("single_rf5",   rf[5], 32'hDEADBEEF);
      chk("single_we_off", 32'(write_enable_o), 32'h0);

      // scoreboard set/clear
      @(negedge clk_i);
      claim_valid_i = 1'b1;
      claim_addr_i  = 5'd7;
      tick();
      chk("sb_busy7_set", 32'(busy_o[7]), 32'h1);
      @(negedge clk_i);
      claim_valid_i    = 1'b0;
      src_valid_i[MDU] = 1'b1;
      src_addr_i[MDU]  = 5'd7;
      src_data_i[MDU]  = 32'h0000_0077;
      #1 chk("sb_ready2", 32'(src_ready_o), 32'h4);
      tick();
      chk("sb_we7",        32'(write_enable_o), 32'h1);
      chk("sb_busy7_hold", 32'(busy_o[7]), 32'h1);
      @(negedge clk_i);
      src_valid_i = 3'b000;
      tick();
      chk("sb_busy7_clr", 32'(busy_o[7]), 32'h0);
      chk("sb_rf7",       rf[7], 32'h0000_0077);
      @(negedge clk_i);
      claim_valid_i = 1'b1;
      claim_addr_i  = 5'd0;
      tick();
      chk("sb_claim_x0", busy_o, 32'h0);
      @(negedge clk_i);
      claim_valid_i = 1'b0;

      // all sources valid: pointer sits at 2 after the MDU grant
      for (int s = 0; s < 3; s++) begin
         src_addr_i[s] = 5'(16 + s);
         src_data_i[s] = 32'hA000_0000 + 32'(s);
      end
      src_valid_i = 3'b111;
      for (int k = 0; k < 6; k++) begin
         #1 chk($sformatf("rr_ready_%0d", k), 32'(src_ready_o), 32'(1 << (k % 3)));
         @(posedge clk_i);
         #1;
         chk($sformatf("rr_we_%0d", k),    32'(write_enable_o), 32'h1);
         chk($sformatf("rr_waddr_%0d", k), 32'(write_addr_o), 32'(16 + k));
         chk($sformatf("rr_wdata_%0d", k), write_data_o, 32'hA000_0000 + 32'(k));
         @(negedge clk_i);
         src_addr_i[k % 3] = 5'(16 + k + 3);
         src_data_i[k % 3] = 32'hA000_0000 + 32'(k + 3);
      end
      src_valid_i = 3'b000;
      tick();
      chk("rr_rf21", rf[21], 32'hA000_0005);

      // write to x0
      @(negedge clk_i);
      src_valid_i[ALU] = 1'b1;
      src_addr_i[ALU]  = 5'd0;
      src_data_i[ALU]  = 32'h0000_1234;
      #1 chk("x0_ready", 32'(src_ready_o), 32'h1);
      tick();
      chk("x0_we", 32'(write_enable_o), 32'h0);
      @(negedge clk_i);
      src_valid_i = 3'b000;
      tick();
      chk("x0_rf0", rf[0], 32'h0);

      // claim/clear collision on x9
      @(negedge clk_i);
      claim_valid_i = 1'b1;
      claim_addr_i  = 5'd9;
      tick();
      @(negedge clk_i);
      claim_valid_i    = 1'b0;
      src_valid_i[LSU] = 1'b1;
      src_addr_i[LSU]  = 5'd9;
      src_data_i[LSU]  = 32'h0000_0099;
      tick();
      chk("col_we9", 32'(write_enable_o), 32'h1);
      @(negedge clk_i);
      src_valid_i   = 3'b000;
      claim_valid_i = 1'b1;
      claim_addr_i  = 5'd9;
      tick();
      chk("col_busy9", 32'(busy_o[9]), 32'h1);
      chk("col_rf9",   rf[9], 32'h0000_0099);
      @(negedge clk_i);
      claim_valid_i = 1'b0;
      // a plain commit of x9 does clear it
      src_valid_i[LSU] = 1'b1;
      src_data_i[LSU]  = 32'h0000_0999;
      tick();
      @(negedge clk_i);
      src_valid_i = 3'b000;
      tick();
      chk("col_busy9_clr", 32'(busy_o[9]), 32'h0);

      // reset mid-operation
      @(negedge clk_i);
      src_valid_i[ALU] = 1'b1;
      src_addr_i[ALU]  = 5'd3;
      src_data_i[ALU]  = 32'h0000_3333;
      claim_valid_i    = 1'b1;
      claim_addr_i     = 5'd5;
      #1 chk("mid_ready0", 32'(src_ready_o), 32'h1);
      @(posedge clk_i);
      #1;
      rst_ni        = 1'b0;
      src_valid_i   = 3'b000;
      claim_valid_i = 1'b0;
      #1 chk("mid_we_gated", 32'(write_enable_o), 32'h0);
      tick();
      chk("mid_busy", busy_o, 32'h0);
      chk("mid_rf3",  rf[3], 32'h0);
      @(negedge clk_i);
      src_valid_i = 3'b111;
      #1 chk("mid_ready_rst", 32'(src_ready_o), 32'h0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1 chk("mid_first_grant", 32'(src_ready_o), 32'h1);
      tick();
      chk("mid_re_we",    32'(write_enable_o), 32'h1);
      chk("mid_re_waddr", 32'(write_addr_o), 32'd3);
      @(negedge clk_i);
      src_valid_i = 3'b000;
      tick();
      chk("mid_re_rf3", rf[3], 32'h0000_3333);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
